wave_warp_pipe: RTL and testbench

// - Pipelined, parametrised vertical-warp stage for the pixel stream: remaps vcount by an hcount-driven offset.
// - Offset is selectable per frame: bypass, cubic ripple or linear shear.
// - A per-frame phase counter animates the warp across frames.
// - Sits between the pixel source and the frame-buffer write stage; pixel data and hcount pass through delay-matched.

---
 rtl/wave_warp_pipe_if.sv | 25 ++
 rtl/wave_warp_pipe.sv | 91 +++++++++
 tb/tb_wave_warp_pipe.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/wave_warp_pipe_if.sv
// wave_warp_pipe_if: pixel-stream bus into and out of the vertical-warp stage
interface wave_warp_pipe_if #(
  parameter int PIX_W = 7,
  parameter int H_W   = 11,
  parameter int V_W   = 10
);
  logic             frame_in;
  logic [1:0]       mode_in;
  logic             data_valid_in;
  logic [H_W-1:0]   hcount_in;
  logic [V_W-1:0]   vcount_in;
  logic [PIX_W-1:0] data_in;
  logic             data_valid_out;
  logic [H_W-1:0]   hcount_out;
  logic [V_W-1:0]   vcount_out;
  logic [PIX_W-1:0] pixel_out;
  modport master (
    output frame_in, mode_in, data_valid_in, hcount_in, vcount_in, data_in,
    input  data_valid_out, hcount_out, vcount_out, pixel_out
  );
  modport slave (
    input  frame_in, mode_in, data_valid_in, hcount_in, vcount_in, data_in,
    output data_valid_out, hcount_out, vcount_out, pixel_out
  );
endinterface

// File: rtl/wave_warp_pipe.sv
// wave_warp_pipe: 4-stage vertical warp remapping vcount by an hcount-driven offset
module wave_warp_pipe #(
  parameter int PIX_W       = 7,
  parameter int H_W         = 11,
  parameter int V_W         = 10,
  parameter int WIDTH       = 240,
  parameter int HEIGHT      = 320,
  parameter int ROOT_A      = 320,
  parameter int ROOT_B      = 120,
  parameter int PHASE_STEP  = 4,
  parameter int SHEAR_SHIFT = 2
) (
  input logic clk_in,
  input logic rst_in,
  wave_warp_pipe_if.slave bus
);
  localparam int XW = H_W + 1;
  localparam int SW = H_W + 2;
  localparam int PW = 2 * SW;
  localparam int OW = 3 * SW;
  localparam int VS = V_W + 2;
  localparam logic signed [SW-1:0] RA  = SW'(ROOT_A);
  localparam logic signed [SW-1:0] RB  = SW'(ROOT_B);
  localparam logic signed [OW-1:0] LIM = OW'(HEIGHT - 1);
  localparam logic signed [VS-1:0] HS  = VS'(HEIGHT);
  logic [H_W-1:0] phase_q;
  logic [1:0] mode_q;
  logic [XW-1:0] ph_sum, x_c;
  logic signed [SW-1:0] xs_c, a1, b1, c1, x1, c2, x2;
  logic signed [PW-1:0] p2;
  logic signed [OW-1:0] off3, cl_c;
  logic signed [VS-1:0] v_c, w_c;
  logic [3:0] vld;
  logic [3:0][PIX_W-1:0] dat;
  logic [3:0][H_W-1:0] hc;
  logic [2:0][V_W-1:0] vc;
  logic [2:0][1:0] md;
  logic [V_W-1:0] vout_q;
  always_comb begin
    ph_sum = XW'(phase_q) + XW'(PHASE_STEP);
    x_c    = XW'(bus.hcount_in) + XW'(phase_q);
    xs_c   = signed'({1'b0, x_c});
    cl_c   = off3 > LIM ? LIM : (off3 < -LIM ? -LIM : off3);
    v_c    = signed'({2'b0, vc[2]}) + VS'(cl_c);
    w_c    = v_c >= HS ? v_c - HS : (v_c[VS-1] ? v_c + HS : v_c);
  end
  // A pixel arriving with frame_in still sees the old phase/mode: they only update at this edge.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      phase_q <= '0;
      mode_q  <= '0;
      vld     <= '0;
      dat     <= '0;
      hc      <= '0;
      vc      <= '0;
      md      <= '0;
      a1      <= '0;
      b1      <= '0;
      c1      <= '0;
      x1      <= '0;
      p2      <= '0;
      c2      <= '0;
      x2      <= '0;
      off3    <= '0;
      vout_q  <= '0;
    end else begin
      if (bus.frame_in) begin
        mode_q  <= bus.mode_in;
        phase_q <= H_W'(ph_sum >= XW'(WIDTH) ? ph_sum - XW'(WIDTH) : ph_sum);
      end
      vld  <= {vld[2:0], bus.data_valid_in};
      dat  <= {dat[2:0], bus.data_in};
      hc   <= {hc[2:0], bus.hcount_in};
      vc   <= {vc[1:0], bus.vcount_in};
      md   <= {md[1:0], mode_q};
      a1   <= (xs_c - RA) >>> 4;
      b1   <= (xs_c - RB) >>> 3;
      c1   <= xs_c >>> 4;
      x1   <= xs_c;
      p2   <= PW'(a1) * PW'(b1);
      c2   <= c1;
      x2   <= x1;
      off3 <= md[1] == 2'd1 ? OW'(p2) * OW'(c2) : (md[1] == 2'd2 ? OW'(x2 >>> SHEAR_SHIFT) : '0);
      vout_q <= !vld[2] ? '0 : (vc[2] >= V_W'(HEIGHT) ? vc[2] : V_W'(w_c));
    end
  end
  assign bus.data_valid_out = vld[3];
  assign bus.pixel_out      = dat[3];
  assign bus.hcount_out     = hc[3];
  assign bus.vcount_out     = vout_q;
endmodule

// File: tb/tb_wave_warp_pipe.sv
// tb_wave_warp_pipe: randomized scoreboard bench for the vertical-warp pipeline
module tb_wave_warp_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  wave_warp_pipe_if bus ();
  wave_warp_pipe dut (.clk_in(clk), .rst_in(rst), .bus(bus));
  typedef struct {int h; int v; int d;} beat_t;
  beat_t q[$];
  beat_t e;
  int errs = 0;
  int checks = 0;
  int m_phase = 0;
  int m_mode = 0;
  function automatic int fdiv(int n, int d);
    int r = n / d;
    if (n % d != 0 && n < 0) r--;
    return r;
  endfunction
  function automatic int model_v(int h, int v);
    int x = h + m_phase;
    int off = 0;
    if (m_mode == 1) off = fdiv(x - 320, 16) * fdiv(x - 120, 8) * fdiv(x, 16);
    else if (m_mode == 2) off = x / 4;
    if (v >= 320) return v;
    if (off > 319) off = 319;
    if (off < -319) off = -319;
    v = v + off;
    if (v >= 320) v -= 320;
    else if (v < 0) v += 320;
    return v;
  endfunction
  task automatic drive(bit vl, int h, int v, int d, bit fr, int md, int ev = -1);
    int x;
    @(negedge clk);
    bus.data_valid_in = vl;
    bus.hcount_in     = 11'(h);
    bus.vcount_in     = 10'(v);
    bus.data_in       = 7'(d);
    bus.frame_in      = fr;
    bus.mode_in       = 2'(md);
    x = ev < 0 ? model_v(h, v) : ev;
    if (vl) q.push_back('{h, x, d});
    if (fr) begin
      m_mode  = md;
      m_phase = (m_phase + 4) % 240;
    end
  endtask
  task automatic idle(int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0);
  endtask
  task automatic frames(int n, int md);
    repeat (n) drive(0, 0, 0, 0, 1, md);
  endtask
  task automatic do_reset(int n);
    @(negedge clk);
    rst = 1'b1;
    bus.data_valid_in = 1'b0;
    bus.frame_in = 1'b0;
    q.delete();
    m_phase = 0;
    m_mode = 0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic drain();
    int t = 0;
    while (q.size() > 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (q.size() > 0) begin
      errs++;
      $display("FAIL drain: %0d beats missing, required 0", q.size());
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (rst) begin
      checks++;
      if (bus.data_valid_out || bus.vcount_out != 0 || bus.hcount_out != 0 || bus.pixel_out != 0) begin
        errs++;
        $display("FAIL reset_outputs: valid=%0d h=%0d v=%0d p=%0d, required all 0",
                 bus.data_valid_out, bus.hcount_out, bus.vcount_out, bus.pixel_out);
      end
    end else if (bus.data_valid_out) begin
      checks++;
      if (q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_valid: h=%0d v=%0d p=%0d, required no valid", bus.hcount_out, bus.vcount_out, bus.pixel_out);
      end else begin
        e = q.pop_front();
        if (int'(bus.hcount_out) != e.h || int'(bus.vcount_out) != e.v || int'(bus.pixel_out) != e.d) begin
          errs++;
          $display("FAIL beat: got h=%0d v=%0d p=%0d, required h=%0d v=%0d p=%0d",
                   bus.hcount_out, bus.vcount_out, bus.pixel_out, e.h, e.v, e.d);
        end
      end
    end else begin
      checks++;
      if (bus.vcount_out != 0) begin
        errs++;
        $display("FAIL idle_vcount: got %0d, required 0", bus.vcount_out);
      end
    end
  end
  initial begin
    bus.frame_in = 1'b0;
    bus.mode_in = 2'd0;
    bus.data_valid_in = 1'b0;
    bus.hcount_in = '0;
    bus.vcount_in = '0;
    bus.data_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) drive(1, i * 20, i * 30, i + 1, 0, 0, i * 30);
    idle(6);
    drain();
    frames(60, 1);
    drive(1, 64, 10, 5, 0, 1, 9);
    drive(1, 0, 77, 6, 0, 1, 77);
    drive(1, 200, 100, 7, 0, 1, 101);
    drive(1, 64, 1, 8, 0, 1, 0);
    drive(1, 200, 318, 9, 0, 1, 319);
    drive(1, 64, 400, 10, 0, 1, 400);
    idle(6);
    drain();
    frames(60, 2);
    drive(1, 100, 300, 11, 0, 2, 5);
    drive(1, 0, 319, 12, 0, 2, 319);
    drive(1, 100, 0, 13, 1, 2, 25);
    drive(1, 100, 0, 14, 0, 0, 26);
    drive(1, 100, 0, 15, 0, 3, 26);
    idle(6);
    drain();
    // The first beat leaves the pipe just before reset; the later three must vanish.
    for (int i = 0; i < 4; i++) drive(1, 30 + i, 40 + i, 20 + i, 0, 2);
    do_reset(2);
    idle(8);
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2047), $urandom_range(0, 511),
            $urandom_range(0, 127), $urandom_range(0, 63) == 0, $urandom_range(0, 3));
    idle(6);
    drain();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
